config_chain_loader: RTL and testbench
======================================

Name: config_chain_loader

Overview:
- Programming controller for the fabric configuration chain (CCFF scan chain).
- Accepts bitstream bytes over a valid/ready stream and serialises them into the chain head, one bit per enabled shift cycle.
- Holds the user fabric in reset during programming and releases it after a settle delay.
- Sits between the bitstream source (SPI/IO bridge) and the fabric top.

Parameters:
- CHAIN_LEN, 512, total configuration bits in the chain (≥1).
- DATA_W, 8, bitstream word width.
- SETTLE_CYC, 4, cycles the fabric reset stays asserted after the last shift (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin programming
- abort  in  1  single-cycle pulse; cancel programming
- bs_data  in  DATA_W  bitstream word
- bs_valid  in  1  bs_data valid
- bs_ready  out  1  loader can accept a word
- ccff_head  out  1  serial config bit into chain head
- prog_en  out  1  shift enable for chain (one bit per high cycle)
- fabric_rst_n  out  1  active-low reset to user fabric
- busy  out  1  programming in progress
- done  out  1  chain fully loaded, fabric released
- bit_count  out  $clog2(CHAIN_LEN+1)  bits shifted so far

Behaviour:
- Reset values: bs_ready=0, ccff_head=0, prog_en=0, fabric_rst_n=0, busy=0, done=0, bit_count=0, state=IDLE.
- States: IDLE, FETCH, SHIFT, SETTLE, DONE.
- IDLE: fabric_rst_n=0. On start, go to FETCH, clear bit_count, set busy=1.
- FETCH: bs_ready=1. On bs_valid&&bs_ready, latch word into shift register; next state SHIFT. Stall indefinitely while bs_valid=0.
- SHIFT: prog_en=1 every cycle, ccff_head = current bit, MSB first. bit_count increments by 1 per cycle.
  - After DATA_W bits, go to FETCH.
  - When bit_count reaches CHAIN_LEN, go to SETTLE immediately, even mid-word. Remaining low-order bits of that final word are discarded.
- Latency: word accepted in cycle N → its MSB on ccff_head with prog_en=1 in cycle N+1. Throughput is DATA_W+1 cycles per word.
- SETTLE: prog_en=0, fabric_rst_n=0 for SETTLE_CYC cycles, then go to DONE.
- DONE: done=1, busy=0, fabric_rst_n=1, bs_ready=0. Excess words are never accepted.
- start in DONE: re-program. done→0, fabric_rst_n→0, go to FETCH next cycle.
- start while busy: ignored.
- abort in any busy state (FETCH/SHIFT/SETTLE): next cycle IDLE, prog_en=0, bs_ready=0, busy=0, done=0, fabric_rst_n=0, bit_count retained. abort in IDLE or DONE: ignored.
- abort and start in the same cycle: abort wins.
- ccff_head holds its last value when prog_en=0; the chain ignores it.
- rst_n asserted mid-operation: all outputs take reset values asynchronously. No partial state is kept.
- prog_en and ccff_head are registered outputs (no combinational path from inputs).

Decomposition:
- Package cfg_loader_pkg holds the state enum (IDLE, FETCH, SHIFT, SETTLE, DONE) and the bit_count width function.
- One natural sub-module, cfg_piso: a DATA_W parallel-in serial-out shifter with load, shift, and bit-index output.
- The FSM, chain counter and settle counter stay in the top module.

Test Plan:
- CHAIN_LEN=16, DATA_W=8, SETTLE_CYC=4. start, then words 0xA5 and 0x3C with valid always high → ccff_head sequence 1010010100111100 on 16 prog_en cycles. done rises 4 cycles after the last shift. bit_count=16.
- CHAIN_LEN=20. Three words 0xFF, 0x00, 0xF0 → 20 shifts; the final word contributes only 1111. The low nibble is dropped. bs_ready stays 0 afterwards; a fourth valid word is never accepted.
- Hold bs_valid=0 for 10 cycles in FETCH → prog_en stays 0, bit_count frozen. Resume → shifting continues with no lost or duplicated bit.
- abort during SHIFT after 5 bits → next cycle prog_en=0, busy=0, done=0, fabric_rst_n=0, bit_count=5. A new start restarts from bit_count=0.
- Assert rst_n=0 during SETTLE → all outputs immediately at reset values. After rst_n release, only a new start resumes programming.
- Pulse start in DONE → done falls and fabric_rst_n falls the next cycle. A full reload completes identically to the first run. A start pulse while busy has no effect.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// Shared types for the configuration chain loader: controller states and counter sizing.
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SHIFT  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cfg_piso.sv
// DATA_W parallel-in serial-out shifter, MSB first; bit_o is the current bit, idx_o counts down to 0.
// Load wins over shift; at idx 0 the register holds so the last bit stays on bit_o.
module cfg_piso #(
    parameter  int DATA_W = 8,
    localparam int IW     = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              shift_i,
    output logic              bit_o,
    output logic [IW-1:0]     idx_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [IW-1:0]     idx_q, idx_d;

    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        if (load_i) begin
            data_d = data_i;
            idx_d  = IW'(DATA_W - 1);
        end else if (shift_i && (idx_q != '0)) begin
            data_d = data_q << 1;
            idx_d  = idx_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

    assign bit_o = data_q[DATA_W-1];
    assign idx_o = idx_q;

endmodule

// File: rtl/config_chain_loader.sv
// Streams bitstream words MSB-first into the config chain, then holds fabric reset for SETTLE_CYC cycles.
// Word accepted in cycle N shows its MSB in N+1; bs_ready only in FETCH, so one word per DATA_W+1 cycles.
module config_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter  int CHAIN_LEN  = 512,
    parameter  int DATA_W     = 8,
    parameter  int SETTLE_CYC = 4,
    localparam int CW         = cnt_width(CHAIN_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              prog_en,
    output logic              fabric_rst_n,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     bit_count
);

    localparam int SW = cnt_width(SETTLE_CYC);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            bs_ready_q, prog_en_q, busy_q, done_q, frst_n_q;

    logic            piso_bit;
    logic [IW-1:0]   piso_idx;
    logic            chain_last, word_last, accept, piso_shift, restart;

    assign chain_last = (bit_cnt_q == CW'(CHAIN_LEN - 1));
    assign word_last  = (piso_idx == '0);
    assign accept     = (state_q == FETCH) && bs_valid && bs_ready_q && !abort;
    assign restart    = ((state_q == IDLE) || (state_q == DONE)) && start && !abort;
    // Freezing the shifter on the final chain bit or on abort keeps ccff_head stable once prog_en drops.
    assign piso_shift = (state_q == SHIFT) && !chain_last && !abort;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        settle_d  = '0;
        case (state_q)
            IDLE: begin
                if (restart) state_d = FETCH;
            end
            FETCH: begin
                if (abort)       state_d = IDLE;
                else if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                // The bit on the chain this cycle is counted even when aborting.
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (abort)           state_d = IDLE;
                else if (chain_last) state_d = SETTLE;
                else if (word_last)  state_d = FETCH;
            end
            SETTLE: begin
                settle_d = settle_q + 1'b1;
                if (abort)                              state_d = IDLE;
                else if (settle_q == SW'(SETTLE_CYC - 1)) state_d = DONE;
            end
            DONE: begin
                if (restart) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
        if (restart) bit_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            settle_q   <= '0;
            bs_ready_q <= 1'b0;
            prog_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            frst_n_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            settle_q   <= settle_d;
            bs_ready_q <= (state_d == FETCH);
            prog_en_q  <= (state_d == SHIFT);
            busy_q     <= (state_d == FETCH) || (state_d == SHIFT) || (state_d == SETTLE);
            done_q     <= (state_d == DONE);
            frst_n_q   <= (state_d == DONE);
        end
    end

    cfg_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .data_i  (bs_data),
        .shift_i (piso_shift),
        .bit_o   (piso_bit),
        .idx_o   (piso_idx)
    );

    assign bs_ready     = bs_ready_q;
    assign ccff_head    = piso_bit;
    assign prog_en      = prog_en_q;
    assign fabric_rst_n = frst_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign bit_count    = bit_cnt_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Randomised bench: accepted words feed a bit-queue model; a negedge monitor checks every chain shift.
module tb_config_chain_loader;

    localparam int CHAIN_LEN  = 20;
    localparam int DATA_W     = 8;
    localparam int SETTLE_CYC = 4;
    localparam int CW         = $clog2(CHAIN_LEN + 1);
    localparam int WORDS      = (CHAIN_LEN + DATA_W - 1) / DATA_W;

    typedef logic [7:0] bq_t[$];

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] bs_data;
    logic              bs_valid;
    logic              bs_ready;
    logic              ccff_head;
    logic              prog_en;
    logic              fabric_rst_n;
    logic              busy;
    logic              done;
    logic [CW-1:0]     bit_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: the chain must see the first CHAIN_LEN bits of the accepted words, MSB first.
    logic exp_q[$];
    logic exp_bit;
    int   exp_cnt     = 0;
    int   queued      = 0;
    int   acc_cnt     = 0;
    int   settle_seen = 0;
    bit   in_settle   = 0;
    bit   pend_first  = 0;
    logic last_head   = 1'b0;

    config_chain_loader #(
        .CHAIN_LEN  (CHAIN_LEN),
        .DATA_W     (DATA_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .bs_data      (bs_data),
        .bs_valid     (bs_valid),
        .bs_ready     (bs_ready),
        .ccff_head    (ccff_head),
        .prog_en      (prog_en),
        .fabric_rst_n (fabric_rst_n),
        .busy         (busy),
        .done         (done),
        .bit_count    (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_cnt     = 0;
        queued      = 0;
        acc_cnt     = 0;
        in_settle   = 0;
        pend_first  = 0;
        settle_seen = 0;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            last_head = 1'b0;
        end else begin
            chk("bit_count", 32'(bit_count), 32'(exp_cnt));
            if (pend_first) begin
                chk("first_bit_latency", 32'(prog_en), 32'd1);
                pend_first = 0;
            end
            if (prog_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_shift", 32'(prog_en), 32'd0);
                end else begin
                    exp_bit = exp_q.pop_front();
                    chk("ccff_head", 32'(ccff_head), 32'(exp_bit));
                    exp_cnt++;
                    if (exp_cnt == CHAIN_LEN) begin
                        in_settle   = 1;
                        settle_seen = 0;
                    end
                end
            end else begin
                chk("ccff_hold", 32'(ccff_head), 32'(last_head));
                if (in_settle) begin
                    if (!done) begin
                        settle_seen++;
                        chk("settle_outputs", 32'({busy, fabric_rst_n, bs_ready}), 32'b100);
                        if (settle_seen > SETTLE_CYC) begin
                            chk("settle_timeout", 32'(settle_seen), 32'(SETTLE_CYC));
                            in_settle = 0;
                        end
                    end else begin
                        chk("settle_len", 32'(settle_seen), 32'(SETTLE_CYC));
                        chk("done_outputs", 32'({busy, fabric_rst_n}), 32'b01);
                        chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
                        in_settle = 0;
                    end
                end
            end
            if (done) chk("done_bs_ready", 32'(bs_ready), 32'd0);
            if (bs_valid && bs_ready) begin
                acc_cnt++;
                pend_first = 1;
                for (int i = DATA_W - 1; i >= 0; i--) begin
                    if (queued < CHAIN_LEN) begin
                        exp_q.push_back(bs_data[i]);
                        queued++;
                    end
                end
            end
            last_head = ccff_head;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        model_clear();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done_low", 32'(done), 32'd0);
        chk("start_fabric_rst", 32'(fabric_rst_n), 32'd0);
        chk("start_bs_ready", 32'(bs_ready), 32'd1);
        chk("start_bit_count", 32'(bit_count), 32'd0);
    endtask

    task automatic pulse_start_busy();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_while_busy", 32'({busy, done}), 32'b10);
    endtask

    task automatic feed_word(input logic [7:0] w);
        bit ok;
        ok       = 0;
        bs_data  = w;
        bs_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bs_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("fetch_timeout", 32'(bs_ready), 32'd1);
        @(posedge clk); #1 bs_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    task automatic run_words(input bq_t ws, input int gmin, input int gmax, input bit busy_start);
        int gap;
        pulse_start();
        foreach (ws[k]) begin
            feed_word(ws[k]);
            if (busy_start && k == 0) pulse_start_busy();
            gap = $urandom_range(gmax, gmin);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        wait_done();
        chk("final_bit_count", 32'(bit_count), CHAIN_LEN);
        // Offer a surplus word: it must never be taken.
        bs_data  = 8'($urandom_range(0, 255));
        bs_valid = 1'b1;
        repeat (12) @(negedge clk);
        @(posedge clk); #1 bs_valid = 1'b0;
        chk("accepted_words", 32'(acc_cnt), WORDS);
    endtask

    function automatic bq_t rand_words();
        bq_t q;
        for (int i = 0; i < WORDS; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    initial begin
        bq_t ws;
        bit  hit;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        bs_data  = '0;
        bs_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({bs_ready, ccff_head, prog_en, fabric_rst_n, busy, done, bit_count}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_outputs", 32'({bs_ready, prog_en, fabric_rst_n, busy, done}), 32'd0);

        // Known words; the last contributes only its high nibble.
        ws = '{8'hA5, 8'h3C, 8'hF0};
        run_words(ws, 0, 0, 0);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_in_done_ignored", 32'({done, fabric_rst_n, busy}), 32'b110);

        // Re-program from DONE, with a start pulse while busy.
        ws = '{8'hFF, 8'h00, 8'hF0};
        run_words(ws, 0, 0, 1);

        // Long source stall between words, then short random stalls.
        run_words(rand_words(), 18, 18, 0);
        run_words(rand_words(), 0, 3, 0);

        // Abort mid-word: the fifth bit is the last one on the chain.
        pulse_start();
        feed_word(8'h5A);
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (prog_en && bit_count == CW'(4)) begin
                hit = 1;
                break;
            end
        end
        if (!hit) chk("abort_reach", 32'(bit_count), 32'd4);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        exp_q.delete();
        pend_first = 0;
        chk("abort_outputs", 32'({prog_en, busy, done, fabric_rst_n, bs_ready}), 32'd0);
        chk("abort_bit_count", 32'(bit_count), 32'd5);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_in_idle_ignored", 32'({busy, done}), 32'b00);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", 32'({busy, bs_ready}), 32'b00);
        run_words(rand_words(), 0, 2, 0);

        // Reset during SETTLE.
        pulse_start();
        ws = rand_words();
        foreach (ws[k]) feed_word(ws[k]);
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (prog_en && bit_count == CW'(CHAIN_LEN - 1)) begin
                hit = 1;
                break;
            end
        end
        if (!hit) chk("settle_reach", 32'(bit_count), 32'(CHAIN_LEN - 1));
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({bs_ready, ccff_head, prog_en, fabric_rst_n, busy, done, bit_count}), 32'd0);
        model_clear();
        @(negedge clk); #1 rst_n = 1'b1;
        model_clear();
        repeat (6) @(negedge clk);
        #1;
        chk("post_reset_idle", 32'({bs_ready, prog_en, busy, done, fabric_rst_n}), 32'd0);

        for (int r = 0; r < 4; r++) begin
            run_words(rand_words(), 0, 4, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
